// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment hex display driver, active-low segments/anodes.
// Optional LEADING_ZERO_BLANK_EN: darkens leading zero digits (digit 0 never suppressed).
module seg_scan_mux #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] hex_in,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out
);

    localparam int unsigned DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]       SEG_OFF  = 7'b1111111;

    // Elaboration-time parameter range guard
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
        $error("seg_scan_mux: NUM_DIGITS must be 1..8");
    end
    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $error("seg_scan_mux: SCAN_DIV must be >= 2");
    end

    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    logic                  tick;
    logic [NUM_DIGITS-1:0] eff_blank;
    logic [3:0]            sel_hex;
    logic                  sel_blank;
    logic                  sel_dp;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; a digit is dark while every digit above and including it is zero
    logic lz_run;
    always_comb begin
        eff_blank = blank;
        lz_run    = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
            lz_run = lz_run & (hex_in[4*i +: 4] == 4'h0);
            if (lz_run) begin
                eff_blank[i] = 1'b1;
            end
        end
    end
`else
    assign eff_blank = blank;
`endif

    // Select the currently scanned digit's value, blank and decimal point
    always_comb begin
        sel_hex   = 4'h0;
        sel_blank = 1'b1;
        sel_dp    = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx_q == IDX_W'(i)) begin
                sel_hex   = hex_in[4*i +: 4];
                sel_blank = eff_blank[i];
                sel_dp    = dp_in[i];
            end
        end
    end

    assign tick = (div_cnt_q == DIV_LAST);

    // Divider, digit pointer and registered output drive
    always_comb begin
        div_cnt_d   = div_cnt_q + DIV_W'(1);
        digit_idx_d = digit_idx_q;
        seg_d       = SEG_OFF;
        dp_d        = 1'b1;
        an_d        = '1;

        if (tick) begin
            div_cnt_d = '0;
            if (digit_idx_q == IDX_LAST) begin
                digit_idx_d = '0;
            end else begin
                digit_idx_d = digit_idx_q + IDX_W'(1);
            end
        end

        if (!sel_blank) begin
            seg_d = glyph(sel_hex);
            dp_d  = ~sel_dp;
            an_d  = ~(NUM_DIGITS'(1) << digit_idx_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q   <= '0;
            digit_idx_q <= '0;
            seg_q       <= SEG_OFF;
            dp_q        <= 1'b1;
            an_q        <= '1;
        end else begin
            div_cnt_q   <= div_cnt_d;
            digit_idx_q <= digit_idx_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
        end
    end

    assign seg_out = seg_q;
    assign dp_out  = dp_q;
    assign an_out  = an_q;

endmodule
